// File: rtl/ecc_hsiao_dec_pipe.sv
// Two-stage pipelined Hsiao SEC-DED decoder with valid/ready handshake.
// Define ECC_DEC_ERR_CNT_EN to build the saturating SGL/DBL error counters.
module ecc_hsiao_dec_pipe #(
    parameter  int DATA_W = 32,
    parameter  int CHK_W  = 7,
    parameter  int CNT_W  = 16,
    localparam int N      = DATA_W + CHK_W,
    localparam int P_W    = $clog2(N)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [N-1:0]      in_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_o,
    output logic [CHK_W-1:0]  syn_o,
    output logic              sgl_o,
    output logic              dbl_o,
    output logic [P_W-1:0]    err_pos_o,
    input  logic              cnt_clr_i,
    output logic [CNT_W-1:0]  sgl_cnt_o,
    output logic [CNT_W-1:0]  dbl_cnt_o
);

    typedef logic [CHK_W-1:0]             col_t;
    typedef logic [DATA_W-1:0][CHK_W-1:0] col_tab_t;

    // Data columns: odd-weight (>=3) vectors taken in ascending numeric order.
    function automatic col_tab_t build_cols();
        col_tab_t tab;
        int       idx;
        tab = '0;
        idx = 0;
        for (int v = 0; v < (1 << CHK_W); v++) begin
            if ($countones(v) >= 3 && ($countones(v) % 2) == 1 && idx < DATA_W) begin
                tab[idx] = v[CHK_W-1:0];
                idx++;
            end
        end
        return tab;
    endfunction

    localparam col_tab_t COLS = build_cols();

    logic              en_a, en_b;
    logic              va_q;
    logic [DATA_W-1:0] data_a_q;
    col_t              syn_a_q;
    col_t              syn_d;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_q, out_d;
    col_t              syn_b_q;
    logic              sgl_q, sgl_d;
    logic              dbl_q, dbl_d;
    logic [P_W-1:0]    pos_q, pos_d;
    logic [N-1:0]      hit;

    assign en_b       = ~out_valid_q | out_ready_i;
    assign en_a       = ~va_q | en_b;
    assign in_ready_o = en_a;

    always_comb begin
        syn_d = in_i[N-1:DATA_W];
        for (int i = 0; i < DATA_W; i++) begin
            if (in_i[i]) syn_d = syn_d ^ COLS[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            va_q     <= 1'b0;
            data_a_q <= '0;
            syn_a_q  <= '0;
        end else if (en_a) begin
            va_q <= in_valid_i;
            if (in_valid_i) begin
                data_a_q <= in_i[DATA_W-1:0];
                syn_a_q  <= syn_d;
            end
        end
    end

    // A nonzero syndrome matches at most one column, so the hit vector is one-hot or zero.
    always_comb begin
        hit   = '0;
        pos_d = '0;
        for (int i = 0; i < DATA_W; i++) hit[i] = (syn_a_q == COLS[i]);
        for (int j = 0; j < CHK_W; j++) hit[DATA_W+j] = (syn_a_q == col_t'(1 << j));
        for (int k = 0; k < N; k++) begin
            if (hit[k]) pos_d = P_W'(k);
        end
        sgl_d = |hit;
        dbl_d = (syn_a_q != '0) & ~sgl_d;
        out_d = data_a_q ^ hit[DATA_W-1:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            out_q       <= '0;
            syn_b_q     <= '0;
            sgl_q       <= 1'b0;
            dbl_q       <= 1'b0;
            pos_q       <= '0;
        end else if (en_b) begin
            out_valid_q <= va_q;
            if (va_q) begin
                out_q   <= out_d;
                syn_b_q <= syn_a_q;
                sgl_q   <= sgl_d;
                dbl_q   <= dbl_d;
                pos_q   <= pos_d;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_o       = out_q;
    assign syn_o       = syn_b_q;
    assign sgl_o       = sgl_q;
    assign dbl_o       = dbl_q;
    assign err_pos_o   = pos_q;

`ifdef ECC_DEC_ERR_CNT_EN
    logic             out_hs;
    logic [CNT_W-1:0] sgl_cnt_q, dbl_cnt_q;

    assign out_hs = out_valid_q & out_ready_i;

    // Clear takes priority; an increment in the same cycle is dropped.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sgl_cnt_q <= '0;
            dbl_cnt_q <= '0;
        end else if (cnt_clr_i) begin
            sgl_cnt_q <= '0;
            dbl_cnt_q <= '0;
        end else if (out_hs) begin
            if (sgl_q && !(&sgl_cnt_q)) sgl_cnt_q <= sgl_cnt_q + 1'b1;
            if (dbl_q && !(&dbl_cnt_q)) dbl_cnt_q <= dbl_cnt_q + 1'b1;
        end
    end

    assign sgl_cnt_o = sgl_cnt_q;
    assign dbl_cnt_o = dbl_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign sgl_cnt_o      = '0;
    assign dbl_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_ecc_hsiao_dec_pipe.sv
// Bench for ecc_hsiao_dec_pipe: directed vector table, stall/reset/counter
// sequences and a randomized stream scored against a behavioural decoder model.
module tb_ecc_hsiao_dec_pipe;

    localparam int DW   = 32;
    localparam int CW   = 7;
    localparam int NW   = DW + CW;
    localparam int PW   = 6;
    localparam int CNTW = 8;
    localparam int CMAX = (1 << CNTW) - 1;
`ifdef ECC_DEC_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [NW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out;
    logic [CW-1:0]   syn;
    logic            sgl, dbl;
    logic [PW-1:0]   pos;
    logic            cnt_clr;
    logic [CNTW-1:0] sgl_cnt, dbl_cnt;

    ecc_hsiao_dec_pipe #(.DATA_W(DW), .CHK_W(CW), .CNT_W(CNTW)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_i(in_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_o(out),
        .syn_o(syn), .sgl_o(sgl), .dbl_o(dbl), .err_pos_o(pos),
        .cnt_clr_i(cnt_clr), .sgl_cnt_o(sgl_cnt), .dbl_cnt_o(dbl_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NW-1:0] cw;
        logic [DW-1:0] out;
        logic [CW-1:0] syn;
        logic          sgl;
        logic          dbl;
        logic [PW-1:0] pos;
    } word_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [NW-1:0] flip;
        logic [DW-1:0] out;
        logic [CW-1:0] syn;
        logic          sgl;
        logic          dbl;
        logic [PW-1:0] pos;
    } vec_t;

    int unsigned cols [NW];
    int          total = 0;
    int          bad   = 0;
    int          sgl_m = 0;
    int          dbl_m = 0;
    word_t       src_q[$];
    word_t       exp_q[$];
    logic        hold_in = 1'b0;
    logic        rdy_seen;
    logic [63:0] snap;
    vec_t        vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Column list straight from the H-matrix rule: odd weight >= 3 ascending, then one-hot checks.
    function automatic void build_cols();
        int idx = 0;
        for (int v = 1; v < 128 && idx < DW; v++) begin
            if ($countones(v) >= 3 && $countones(v) % 2 == 1) begin
                cols[idx] = v;
                idx++;
            end
        end
        for (int j = 0; j < CW; j++) cols[DW+j] = 1 << j;
    endfunction

    function automatic logic [CW-1:0] syn_of(input logic [NW-1:0] cw);
        int unsigned s = 0;
        for (int i = 0; i < NW; i++) if (cw[i]) s = s ^ cols[i];
        return s[CW-1:0];
    endfunction

    function automatic logic [NW-1:0] encode(input logic [DW-1:0] d);
        logic [NW-1:0] cw;
        cw = {{CW{1'b0}}, d};
        cw[NW-1:DW] = syn_of(cw);
        return cw;
    endfunction

    function automatic word_t model(input logic [NW-1:0] cw);
        word_t w;
        int    k = -1;
        w.cw  = cw;
        w.syn = syn_of(cw);
        for (int i = 0; i < NW; i++) if (w.syn != 0 && cols[i] == w.syn) k = i;
        w.sgl = (k >= 0);
        w.dbl = (w.syn != 0) && (k < 0);
        w.pos = (k >= 0) ? PW'(k) : '0;
        w.out = cw[DW-1:0];
        if (k >= 0 && k < DW) w.out[k] = ~w.out[k];
        return w;
    endfunction

    function automatic logic [NW-1:0] rand_mask(input int nbits);
        logic [NW-1:0] m = '0;
        while ($countones(m) < nbits) m[$urandom_range(0, NW-1)] = 1'b1;
        return m;
    endfunction

    task automatic push_rand(input int nbits);
        src_q.push_back(model(encode($urandom) ^ rand_mask(nbits)));
    endtask

    // One clock: present inputs, score any output handshake, record any input handshake.
    task automatic tick();
        in_valid = (src_q.size() > 0) && !hold_in;
        if (src_q.size() > 0) in_data = src_q[0].cw;
        #1;
        rdy_seen = in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                word_t e;
                e = exp_q.pop_front();
                check("word", {out, syn, sgl, dbl, pos}, {e.out, e.syn, e.sgl, e.dbl, e.pos});
                if (!cnt_clr) begin
                    if (e.sgl && sgl_m < CMAX) sgl_m++;
                    if (e.dbl && dbl_m < CMAX) dbl_m++;
                end
            end
        end
        if (cnt_clr) begin
            sgl_m = 0;
            dbl_m = 0;
        end
        if (in_valid && in_ready) exp_q.push_back(src_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        for (int n = 0; n < budget && (src_q.size() > 0 || exp_q.size() > 0); n++) tick();
        check("drain_empty", src_q.size() + exp_q.size(), 0);
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_sgl_cnt"}, sgl_cnt, CNT_EN ? sgl_m : 0);
        check({tag, "_dbl_cnt"}, dbl_cnt, CNT_EN ? dbl_m : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        build_cols();
        #2;
        check("reset_outputs", {out_valid, out, syn, sgl, dbl, pos, sgl_cnt, dbl_cnt}, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        vecs[0] = '{32'hDEADBEEF, 39'h00_0000_0000, 32'hDEADBEEF, 7'h00, 1'b0, 1'b0, 6'd0};
        vecs[1] = '{32'hDEADBEEF, 39'h00_0000_0020, 32'hDEADBEEF, 7'h15, 1'b1, 1'b0, 6'd5};
        vecs[2] = '{32'hDEADBEEF, 39'h04_0000_0000, 32'hDEADBEEF, 7'h04, 1'b1, 1'b0, 6'd34};
        vecs[3] = '{32'hDEADBEEF, 39'h00_0002_0008, 32'hDEAFBEE7, 7'h21, 1'b0, 1'b1, 6'd0};
        vecs[4] = '{32'h00000000, 39'h40_0000_0000, 32'h00000000, 7'h40, 1'b1, 1'b0, 6'd38};
        vecs[5] = '{32'h00000000, 39'h01_0000_0001, 32'h00000001, 7'h06, 1'b0, 1'b1, 6'd0};
        vecs[6] = '{32'h12345678, 39'h70_0000_0000, 32'h12345678, 7'h70, 1'b0, 1'b1, 6'd0};
        vecs[7] = '{32'hFFFFFFFF, 39'h00_8000_0000, 32'hFFFFFFFF, 7'h4C, 1'b1, 1'b0, 6'd31};
        out_ready = 1'b1;
        foreach (vecs[i]) begin
            word_t w;
            w.cw  = encode(vecs[i].data) ^ vecs[i].flip;
            w.out = vecs[i].out;
            w.syn = vecs[i].syn;
            w.sgl = vecs[i].sgl;
            w.dbl = vecs[i].dbl;
            w.pos = vecs[i].pos;
            src_q.push_back(w);
        end
        drain(50);
        check_cnt("table");

        // Backpressure: two words fill the pipe, then the input must stall.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_rand(i % 2);
        tick();
        tick();
        snap = {out_valid, out, syn, sgl, dbl, pos};
        tick();
        check("in_ready_full", rdy_seen, 0);
        check("held_words", exp_q.size(), 2);
        check("stall_stable", {out_valid, out, syn, sgl, dbl, pos}, snap);
        check("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        drain(50);

        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 9);
            push_rand(r < 4 ? 0 : r < 7 ? 1 : r < 9 ? 2 : 3);
        end
        for (int n = 0; n < 5000 && (src_q.size() > 0 || exp_q.size() > 0); n++) begin
            hold_in   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        hold_in   = 1'b0;
        out_ready = 1'b1;
        drain(50);
        check_cnt("random");

        for (int i = 0; i < 300; i++) push_rand(1);
        drain(400);
        check("sgl_saturated", sgl_cnt, CNT_EN ? CMAX : 0);
        check_cnt("sat");

        // Clear coinciding with a single-error handshake must leave zero.
        push_rand(1);
        for (int n = 0; n < 10 && !out_valid; n++) tick();
        check("clr_word_ready", out_valid, 1);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_sgl_zero", sgl_cnt, 0);
        check("clr_dbl_zero", dbl_cnt, 0);
        check_cnt("clr");

        // Reset with two words in flight.
        push_rand(1);
        push_rand(2);
        tick();
        tick();
        check("inflight_valid", out_valid, 1);
        rst = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_counters", {sgl_cnt, dbl_cnt}, 0);
        src_q.delete();
        exp_q.delete();
        sgl_m = 0;
        dbl_m = 0;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        push_rand(1);
        tick();
        check("post_rst_lat1", out_valid, 0);
        tick();
        check("post_rst_lat2", out_valid, 1);
        tick();
        drain(10);
        check_cnt("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
